// File: rtl/syn_frame_parser_pkg.sv
// -----------------------------------------------------------------------------
// syn_frame_parser_pkg
//   Shared sync-protocol definitions. Both the sync frame parser and the sync
//   transmitter use this package.
//   Contents: default EtherType, local/broadcast MAC, message codes, frame beat
//   offsets, beat0/beat1 header layouts and a code range helper.
// -----------------------------------------------------------------------------
package syn_frame_parser_pkg;

    // Protocol defaults
    localparam logic [15:0] SYN_ETHERTYPE_DEF = 16'hff03;
    localparam logic [47:0] SYN_MY_MAC_DEF    = 48'h8D_BC_5C_4A_1A_1F;
    localparam logic [47:0] SYN_BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          SYN_MAX_BEATS_DEF = 16;

    // Message codes
    localparam logic [7:0] SYN_CODE_SLAVE_TS  = 8'h01;
    localparam logic [7:0] SYN_CODE_RETURN_TS = 8'h02;
    localparam logic [7:0] SYN_CODE_STD_TIME  = 8'h03;
    localparam logic [7:0] SYN_CODE_CTRL      = 8'h04;

    // Beat offsets inside a frame (64-bit beats, 0-based)
    localparam int SYN_BEAT_HDR0    = 0;
    localparam int SYN_BEAT_HDR1    = 1;
    localparam int SYN_BEAT_PAYLOAD = 2;
    localparam int SYN_BEAT_LAST    = 7;
    localparam int SYN_FRAME_BEATS  = 8;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [15:0] src_mac_hi;
    } syn_beat0_t;

    typedef struct packed {
        logic [31:0] src_mac_lo;
        logic [15:0] ethertype;
        logic [7:0]  code;
        logic [7:0]  slot_id;
    } syn_beat1_t;

    function automatic logic syn_code_valid(input logic [7:0] code);
        return (code >= SYN_CODE_SLAVE_TS) && (code <= SYN_CODE_CTRL);
    endfunction

endpackage

// File: rtl/syn_frame_parser_sat_cnt16.sv
// -----------------------------------------------------------------------------
// sat_cnt16
//   16-bit counter that sticks at 16'hFFFF instead of wrapping.
//   Ports: clk_i, rst_ni (async, active-low), inc_i (count enable),
//          cnt_o (current count).
// -----------------------------------------------------------------------------
module sat_cnt16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/syn_frame_parser.sv
// -----------------------------------------------------------------------------
// syn_frame_parser
//   Parses fixed-format 64-bit sync/control frames from an AXI-Stream receive
//   port with no back-pressure. Accepted frames update the output register that
//   belongs to their message code and pulse its strobe one cycle after tlast.
//   Ports:
//     i_clk, i_rst_n                     clock, async active-low reset
//     s_rx_axis_t{valid,data,last,keep,user}  receive stream
//     o_recv_time_stamp / o_recv_ts_valid     code 01 payload + strobe
//     o_recv_return_ts  / o_recv_return_valid code 02 payload + strobe
//     o_recv_std_time   / o_recv_std_valid    code 03 payload + strobe
//     o_cur_slot_id, o_syn_start              code 04 slot id, start pulse
//     o_frame_cnt, o_drop_cnt                 saturating frame counters
// -----------------------------------------------------------------------------
module syn_frame_parser
    import syn_frame_parser_pkg::*;
#(
    parameter logic [15:0] P_SLOT_ID_TYPE = SYN_ETHERTYPE_DEF,
    parameter logic [47:0] P_MY_MAC       = SYN_MY_MAC_DEF,
    parameter int          P_MAX_BEATS    = SYN_MAX_BEATS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        s_rx_axis_tvalid,
    input  logic [63:0] s_rx_axis_tdata,
    input  logic        s_rx_axis_tlast,
    input  logic [7:0]  s_rx_axis_tkeep,
    input  logic        s_rx_axis_tuser,
    output logic [63:0] o_recv_time_stamp,
    output logic        o_recv_ts_valid,
    output logic [63:0] o_recv_return_ts,
    output logic        o_recv_return_valid,
    output logic [63:0] o_recv_std_time,
    output logic        o_recv_std_valid,
    output logic [7:0]  o_cur_slot_id,
    output logic        o_syn_start,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PAD     = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    // Index of the last beat a frame may carry without tlast before it is
    // discarded; the counter holds the index of the beat currently on the bus.
    localparam logic [3:0] BEAT_LIMIT = 4'(P_MAX_BEATS - 1);

    logic [2:0]  state_q,   state_d;
    logic [3:0]  beat_q,    beat_d;
    logic [7:0]  code_q,    code_d;
    logic [7:0]  slot_q,    slot_d;
    logic [63:0] payload_q, payload_d;
    logic        accept, drop;

    logic [63:0] ts_q, ret_q, std_q;
    logic        ts_vld_q, ret_vld_q, std_vld_q, syn_q;
    logic [7:0]  cur_slot_q;

    syn_beat0_t  b0;
    syn_beat1_t  b1;
    logic        dest_ok, hdr_ok;

    assign b0      = syn_beat0_t'(s_rx_axis_tdata);
    assign b1      = syn_beat1_t'(s_rx_axis_tdata);
    assign dest_ok = (b0.dst_mac == P_MY_MAC) || (b0.dst_mac == SYN_BCAST_MAC);
    assign hdr_ok  = (b1.ethertype == P_SLOT_ID_TYPE) && syn_code_valid(b1.code);

    // Source MAC and tkeep carry nothing this parser acts on.
    logic unused_bits;
    assign unused_bits = ^{s_rx_axis_tkeep, b0.src_mac_hi, b1.src_mac_lo};

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        slot_d    = slot_q;
        payload_d = payload_q;
        accept    = 1'b0;
        drop      = 1'b0;
        if (s_rx_axis_tvalid) begin
            case (state_q)
                S_IDLE: begin
                    if (s_rx_axis_tlast) drop = 1'b1;  // single-beat frame
                    else if (dest_ok)    state_d = S_HDR;
                    else                 state_d = S_DROP;
                end
                S_HDR: begin
                    if (s_rx_axis_tlast) begin
                        drop    = 1'b1;
                        state_d = S_IDLE;
                    end else if (hdr_ok) begin
                        code_d  = b1.code;
                        slot_d  = b1.slot_id;
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_PAYLOAD: begin
                    payload_d = s_rx_axis_tdata;
                    if (s_rx_axis_tlast) begin
                        accept  = !s_rx_axis_tuser;
                        drop    = s_rx_axis_tuser;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAD;
                    end
                end
                S_PAD: begin
                    if (s_rx_axis_tlast) begin
                        accept  = !s_rx_axis_tuser;
                        drop    = s_rx_axis_tuser;
                        state_d = S_IDLE;
                    end else if (beat_q == BEAT_LIMIT) begin
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (s_rx_axis_tlast) begin
                        drop    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (s_rx_axis_tvalid) beat_d = s_rx_axis_tlast ? 4'd0 : beat_q + 4'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            code_q    <= '0;
            slot_q    <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            code_q    <= code_d;
            slot_q    <= slot_d;
            payload_q <= payload_d;
        end
    end

    // payload_d already holds beat2 when tlast lands on the payload beat, so it
    // is the right source for both the short and the padded frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_q       <= '0;
            ret_q      <= '0;
            std_q      <= '0;
            cur_slot_q <= '0;
            ts_vld_q   <= 1'b0;
            ret_vld_q  <= 1'b0;
            std_vld_q  <= 1'b0;
            syn_q      <= 1'b0;
        end else begin
            ts_vld_q  <= 1'b0;
            ret_vld_q <= 1'b0;
            std_vld_q <= 1'b0;
            syn_q     <= 1'b0;
            if (accept) begin
                case (code_q)
                    SYN_CODE_SLAVE_TS: begin
                        ts_q     <= payload_d;
                        ts_vld_q <= 1'b1;
                    end
                    SYN_CODE_RETURN_TS: begin
                        ret_q     <= payload_d;
                        ret_vld_q <= 1'b1;
                    end
                    SYN_CODE_STD_TIME: begin
                        std_q     <= payload_d;
                        std_vld_q <= 1'b1;
                    end
                    SYN_CODE_CTRL: begin
                        cur_slot_q <= slot_q;
                        syn_q      <= payload_d[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_cnt16 u_frame_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .inc_i  (accept),
        .cnt_o  (o_frame_cnt)
    );

    sat_cnt16 u_drop_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .inc_i  (drop),
        .cnt_o  (o_drop_cnt)
    );

    assign o_recv_time_stamp   = ts_q;
    assign o_recv_ts_valid     = ts_vld_q;
    assign o_recv_return_ts    = ret_q;
    assign o_recv_return_valid = ret_vld_q;
    assign o_recv_std_time     = std_q;
    assign o_recv_std_valid    = std_vld_q;
    assign o_cur_slot_id       = cur_slot_q;
    assign o_syn_start         = syn_q;

endmodule

// File: tb/tb_syn_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_syn_frame_parser
//   Frame-level bench: a table of directed frames with expected strobes, a few
//   hand sequences (back-to-back, mid-frame reset) and random frames. A
//   frame-level reference model predicts accept/drop and the output registers.
// -----------------------------------------------------------------------------
module tb_syn_frame_parser;

    localparam logic [47:0] MY_MAC = 48'h8D_BC_5C_4A_1A_1F;
    localparam logic [47:0] BC_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE  = 16'hff03;
    localparam int          MAXB   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid, tlast, tuser;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [63:0] o_ts, o_ret, o_std;
    logic        o_ts_v, o_ret_v, o_std_v, o_syn;
    logic [7:0]  o_slot;
    logic [15:0] o_fcnt, o_dcnt;

    always #5 clk = ~clk;

    syn_frame_parser dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .s_rx_axis_tvalid    (tvalid),
        .s_rx_axis_tdata     (tdata),
        .s_rx_axis_tlast     (tlast),
        .s_rx_axis_tkeep     (tkeep),
        .s_rx_axis_tuser     (tuser),
        .o_recv_time_stamp   (o_ts),
        .o_recv_ts_valid     (o_ts_v),
        .o_recv_return_ts    (o_ret),
        .o_recv_return_valid (o_ret_v),
        .o_recv_std_time     (o_std),
        .o_recv_std_valid    (o_std_v),
        .o_cur_slot_id       (o_slot),
        .o_syn_start         (o_syn),
        .o_frame_cnt         (o_fcnt),
        .o_drop_cnt          (o_dcnt)
    );

    typedef struct {
        int          cyc;
        bit          ok;
        logic [7:0]  code;
        logic [7:0]  slot;
        logic [63:0] pay;
    } ev_t;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        logic [7:0]  code;
        logic [7:0]  slot;
        logic [63:0] pay;
        int          len;
        bit          tu;
        int          gap;
        logic [3:0]  exp_strb;   // {ts, return, std, syn_start}
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          ts_cyc = -1;
    int          std_cyc = -1;
    ev_t         evq[$];
    logic [63:0] m_ts, m_ret, m_std;
    logic [7:0]  m_slot;
    logic [15:0] m_fcnt, m_dcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is accepted iff it is 3..MAXB beats long, is
    // addressed to us or broadcast, has the sync EtherType, a code in 1..4 and
    // no tuser on its last beat. Everything else is exactly one drop.
    function automatic bit model_ok(input logic [63:0] b[$], input bit tu);
        logic [47:0] d;
        logic [15:0] et;
        logic [7:0]  cd;
        if (b.size() < 3 || b.size() > MAXB || tu) return 1'b0;
        d  = b[0][63:16];
        et = b[1][31:16];
        cd = b[1][15:8];
        return ((d == MY_MAC) || (d == BC_MAC)) && (et == ETYPE) && (cd >= 8'd1) && (cd <= 8'd4);
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic monitor_check();
        logic [3:0] se, sa;
        ev_t        ev;
        sa = {o_ts_v, o_ret_v, o_std_v, o_syn};
        if (!rst_n) begin
            m_ts = '0; m_ret = '0; m_std = '0; m_slot = '0; m_fcnt = '0; m_dcnt = '0;
            evq.delete();
            chk("rst_strobes", {60'd0, sa}, 64'd0);
            chk("rst_data", o_ts | o_ret | o_std, 64'd0);
            chk("rst_slot_cnt", {40'd0, o_slot, o_fcnt, o_dcnt}, 64'd0);
            return;
        end
        se = 4'b0;
        if (evq.size() != 0 && evq[0].cyc == cyc) begin
            ev = evq.pop_front();
            if (ev.ok) begin
                if (m_fcnt != 16'hFFFF) m_fcnt++;
                case (ev.code)
                    8'd1: begin m_ts  = ev.pay; se[3] = 1'b1; end
                    8'd2: begin m_ret = ev.pay; se[2] = 1'b1; end
                    8'd3: begin m_std = ev.pay; se[1] = 1'b1; end
                    default: begin m_slot = ev.slot; se[0] = ev.pay[0]; end
                endcase
            end else begin
                if (m_dcnt != 16'hFFFF) m_dcnt++;
            end
        end
        chk("strobes", {60'd0, sa}, {60'd0, se});
        chk("time_stamp", o_ts, m_ts);
        chk("return_ts", o_ret, m_ret);
        chk("std_time", o_std, m_std);
        chk("slot_id", {56'd0, o_slot}, {56'd0, m_slot});
        chk("frame_cnt", {48'd0, o_fcnt}, {48'd0, m_fcnt});
        chk("drop_cnt", {48'd0, o_dcnt}, {48'd0, m_dcnt});
        if (o_ts_v)  ts_cyc  = cyc;
        if (o_std_v) std_cyc = cyc;
    endtask

    // One clock: check outputs mid-cycle, let the DUT sample, move on.
    task automatic step();
        @(negedge clk);
        monitor_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_step();
        tvalid = 1'b0;
        tdata  = {$urandom, $urandom};
        tlast  = 1'($urandom);
        tuser  = 1'($urandom);
        tkeep  = 8'($urandom);
        step();
    endtask

    task automatic mk_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] code,
                            input logic [7:0] slot, input logic [63:0] pay, input int len,
                            output logic [63:0] b[$]);
        logic [63:0] r;
        b.delete();
        for (int i = 0; i < len; i++) begin
            r = {$urandom, $urandom};
            if (i == 0)      b.push_back({dst, r[15:0]});
            else if (i == 1) b.push_back({r[31:0], et, code, slot});
            else if (i == 2) b.push_back(pay);
            else             b.push_back(r);
        end
    endtask

    task automatic send_frame(input logic [63:0] b[$], input bit tu, input int gapmax);
        int  g;
        bit  last;
        ev_t ev;
        for (int i = 0; i < b.size(); i++) begin
            if (gapmax > 0) begin
                g = $urandom_range(gapmax, 0);
                repeat (g) idle_step();
            end
            last   = (i == b.size() - 1);
            tvalid = 1'b1;
            tdata  = b[i];
            tlast  = last;
            tkeep  = 8'($urandom);
            tuser  = last ? tu : 1'($urandom);
            if (last) begin
                ev.cyc  = cyc + 1;
                ev.ok   = model_ok(b, tu);
                ev.code = (b.size() > 1) ? b[1][15:8] : 8'd0;
                ev.slot = (b.size() > 1) ? b[1][7:0]  : 8'd0;
                ev.pay  = (b.size() > 2) ? b[2]       : 64'd0;
                evq.push_back(ev);
            end
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    vec_t        tv[16];
    logic [63:0] fb[$];
    logic [63:0] tail[$];
    logic [63:0] rnd;
    logic [47:0] dst;
    int          len;

    initial begin
        // Directed frames; expected strobe = {ts, return, std, syn_start}.
        tv[0]  = '{MY_MAC, ETYPE,    8'h02, 8'h00, 64'h1234,        8,  1'b0, 0, 4'b0100};
        tv[1]  = '{MY_MAC, ETYPE,    8'h04, 8'h05, 64'h1,           8,  1'b0, 0, 4'b0001};
        tv[2]  = '{MY_MAC, ETYPE,    8'h04, 8'h06, 64'h2,           8,  1'b0, 1, 4'b0000};
        tv[3]  = '{MY_MAC, 16'h0800, 8'h01, 8'h00, 64'h55,          8,  1'b0, 0, 4'b0000};
        tv[4]  = '{MY_MAC, ETYPE,    8'h01, 8'h00, 64'h66,          2,  1'b0, 0, 4'b0000};
        tv[5]  = '{MY_MAC, ETYPE,    8'h01, 8'h00, 64'h77,          8,  1'b1, 0, 4'b0000};
        tv[6]  = '{MY_MAC, ETYPE,    8'h03, 8'h00, 64'h88,          20, 1'b0, 0, 4'b0000};
        tv[7]  = '{MY_MAC, ETYPE,    8'h01, 8'h00, 64'hABCD_0001,   8,  1'b0, 0, 4'b1000};
        tv[8]  = '{BC_MAC, ETYPE,    8'h03, 8'h00, 64'hFEED_BEEF,   8,  1'b0, 2, 4'b0010};
        tv[9]  = '{48'h0011_2233_4455, ETYPE, 8'h01, 8'h00, 64'h9,  8,  1'b0, 0, 4'b0000};
        tv[10] = '{MY_MAC, ETYPE,    8'h05, 8'h00, 64'hA,           8,  1'b0, 0, 4'b0000};
        tv[11] = '{MY_MAC, ETYPE,    8'h01, 8'h00, 64'h3333,        3,  1'b0, 0, 4'b1000};
        tv[12] = '{MY_MAC, ETYPE,    8'h02, 8'h00, 64'h1616,        16, 1'b0, 1, 4'b0100};
        tv[13] = '{MY_MAC, ETYPE,    8'h02, 8'h00, 64'h1717,        17, 1'b0, 0, 4'b0000};
        tv[14] = '{MY_MAC, ETYPE,    8'h01, 8'h00, 64'h1,           1,  1'b0, 0, 4'b0000};
        tv[15] = '{MY_MAC, ETYPE,    8'h00, 8'h00, 64'h2,           8,  1'b0, 0, 4'b0000};

        rst_n  = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; tkeep = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) idle_step();

        foreach (tv[k]) begin
            mk_frame(tv[k].dst, tv[k].et, tv[k].code, tv[k].slot, tv[k].pay, tv[k].len, fb);
            send_frame(fb, tv[k].tu, tv[k].gap);
            chk($sformatf("vec%0d_strobe", k), {60'd0, o_ts_v, o_ret_v, o_std_v, o_syn},
                {60'd0, tv[k].exp_strb});
            if (k == 0) begin
                chk("vec0_return_ts", o_ret, 64'h1234);
                chk("vec0_frame_cnt", {48'd0, o_fcnt}, 64'd1);
            end
            if (k == 2) chk("vec2_slot", {56'd0, o_slot}, 64'd6);
            if (k == 5) chk("vec5_drop_cnt", {48'd0, o_dcnt}, 64'd3);
            repeat (2) idle_step();
        end

        // Back-to-back code 01 then code 03, no idle gap.
        ts_cyc = -1; std_cyc = -1;
        mk_frame(MY_MAC, ETYPE, 8'h01, 8'h00, 64'hB2B_0001, 8, fb);
        send_frame(fb, 1'b0, 0);
        mk_frame(MY_MAC, ETYPE, 8'h03, 8'h00, 64'hB2B_0003, 8, fb);
        send_frame(fb, 1'b0, 0);
        repeat (2) idle_step();
        chk("b2b_seen", {62'd0, ts_cyc >= 0, std_cyc >= 0}, 64'd3);
        chk("b2b_spacing", 64'(std_cyc - ts_cyc), 64'd8);
        chk("b2b_ts", o_ts, 64'hB2B_0001);
        chk("b2b_std", o_std, 64'hB2B_0003);

        // Random frames against the model.
        for (int n = 0; n < 150; n++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(9, 0))
                0, 1, 2, 3, 4: dst = MY_MAC;
                5, 6, 7:       dst = BC_MAC;
                default:       dst = rnd[47:0];
            endcase
            case ($urandom_range(7, 0))
                0:       len = 1;
                1:       len = 2;
                2:       len = 3;
                3:       len = 16;
                4:       len = 17;
                5:       len = $urandom_range(20, 4);
                default: len = 8;
            endcase
            mk_frame(dst, ($urandom_range(9, 0) < 8) ? ETYPE : 16'($urandom),
                     8'($urandom_range(5, 0)), 8'($urandom), {$urandom, $urandom}, len, fb);
            send_frame(fb, $urandom_range(9, 0) == 0, $urandom_range(2, 0));
            repeat ($urandom_range(2, 0)) idle_step();
        end

        // Reset lands on beat 4 of a code-03 frame; beats 5..7 then form a
        // fresh frame whose first beat is padding, so it must end as a drop.
        mk_frame(MY_MAC, ETYPE, 8'h03, 8'h00, 64'h5EED, 8, fb);
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1; tdata = fb[i]; tlast = 1'b0; tuser = 1'b0; tkeep = 8'hFF;
            step();
        end
        tdata = fb[4];
        rst_n = 1'b0;
        step();
        tvalid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        tail.delete();
        for (int i = 5; i < 8; i++) tail.push_back(fb[i]);
        send_frame(tail, 1'b0, 0);
        repeat (2) idle_step();
        chk("rst_tail_drop", {48'd0, o_dcnt}, 64'd1);
        chk("rst_tail_fcnt", {48'd0, o_fcnt}, 64'd0);
        chk("rst_no_std", o_std, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
